jump_ctrl: RTL and testbench

- Game-flow sequencer for the jumping man.
- Turns the player key into a charge, drives the jump datapath's enable, length, tall and moved_man_x inputs, and checks the landing point against the target platform.
- After a landing it scrolls the scene back to the home column, then fires generate_en for a new platform.
- Sits between key debounce / frame-tick logic and the jump datapath and platform generator.

---
 rtl/jump_pkg.sv | 26 ++
 rtl/jump_ctrl_if.sv | 33 +++
 rtl/jump_ctrl_key_edge.sv | 19 +
 rtl/jump_ctrl.sv | 159 +++++++++++++++
 tb/tb_jump_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jump_pkg.sv
// Shared definitions for the jumping-man game: coordinate width, home column,
// ground line and the game-flow state encoding.
package jump_pkg;

  localparam int COORD_W    = 10;
  localparam int MAN_HOME_X = 60;
  localparam int GROUND_Y   = 500;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_JUMP,
    S_CHECK,
    S_SCROLL,
    S_NEWPLAT,
    S_OVER
  } state_t;

  // Inclusive span test used for the landing check.
  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/jump_ctrl_if.sv
// Signal bundle between the game-flow sequencer (master) and the key/frame
// logic, jump datapath and platform generator around it (slave).
interface jump_ctrl_if;
  import jump_pkg::*;

  logic       pulse;
  logic       key;
  logic       jump_fin;
  coord_t     man_x;
  coord_t     plat_left;
  coord_t     plat_right;
  logic       jump_en;
  coord_t     length;
  coord_t     tall;
  coord_t     moved_man_x;
  logic       scroll_pulse;
  logic       generate_en;
  logic [7:0] score;
  logic       game_over;

  modport master (
    input  pulse, key, jump_fin, man_x, plat_left, plat_right,
    output jump_en, length, tall, moved_man_x, scroll_pulse, generate_en,
           score, game_over
  );

  modport slave (
    output pulse, key, jump_fin, man_x, plat_left, plat_right,
    input  jump_en, length, tall, moved_man_x, scroll_pulse, generate_en,
           score, game_over
  );

endinterface

// File: rtl/jump_ctrl_key_edge.sv
// Rising-edge detector for the debounced jump key.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_rise
);

  logic key_q;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= 1'b0;
    else     key_q <= key;
  end

  assign key_rise = key & ~key_q;

endmodule

// File: rtl/jump_ctrl.sv
// Game-flow sequencer: charges a jump from the key, runs the jump, scores the
// landing, scrolls the scene back to the home column and requests a platform.
module jump_ctrl #(
  parameter int MAN_HOME_X   = jump_pkg::MAN_HOME_X,
  parameter int LEN_MIN      = 20,
  parameter int LEN_MAX      = 600,
  parameter int LEN_STEP     = 4,
  parameter int TALL_REST    = 60,
  parameter int TALL_MIN     = 30,
  parameter int SCROLL_STEP  = 4,
  parameter int JUMP_TIMEOUT = 512
) (
  input  logic        clk,
  input  logic        rst,
  jump_ctrl_if.master bus
);
  import jump_pkg::*;

  localparam coord_t     HOME_C      = coord_t'(MAN_HOME_X);
  localparam coord_t     SNAP_C      = coord_t'(MAN_HOME_X + SCROLL_STEP);
  localparam coord_t     STEP_C      = coord_t'(SCROLL_STEP);
  localparam coord_t     LEN_MIN_C   = coord_t'(LEN_MIN);
  localparam coord_t     LEN_MAX_C   = coord_t'(LEN_MAX);
  localparam coord_t     LEN_STEP_C  = coord_t'(LEN_STEP);
  localparam coord_t     LEN_GROW_C  = coord_t'(LEN_MAX - LEN_STEP);
  localparam coord_t     TALL_REST_C = coord_t'(TALL_REST);
  localparam coord_t     TALL_MIN_C  = coord_t'(TALL_MIN);
  localparam logic [15:0] TO_LAST    = 16'(JUMP_TIMEOUT - 1);

  state_t      state;
  logic        key_rise;
  coord_t      land_x;
  logic [15:0] to_cnt;

  logic        jump_en;
  coord_t      length;
  coord_t      tall;
  coord_t      moved_man_x;
  logic        scroll_pulse;
  logic        generate_en;
  logic [7:0]  score;
  logic        game_over;

  key_edge u_key_edge (
    .clk      (clk),
    .rst      (rst),
    .key      (bus.key),
    .key_rise (key_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      jump_en      <= 1'b0;
      length       <= LEN_MIN_C;
      tall         <= TALL_REST_C;
      moved_man_x  <= HOME_C;
      scroll_pulse <= 1'b0;
      generate_en  <= 1'b0;
      score        <= 8'd0;
      game_over    <= 1'b0;
      land_x       <= '0;
      to_cnt       <= '0;
    end else begin
      // NOTE: strobes default low here so each set below lasts exactly one cycle.
      scroll_pulse <= 1'b0;
      generate_en  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (key_rise) begin
            state  <= S_CHARGE;
            length <= LEN_MIN_C;
            tall   <= TALL_REST_C;
          end
        end

        S_CHARGE: begin
          if (!bus.key) begin
            state   <= S_JUMP;
            jump_en <= 1'b1;
            to_cnt  <= '0;
          end else if (bus.pulse) begin
            length <= (length >= LEN_GROW_C) ? LEN_MAX_C : length + LEN_STEP_C;
            tall   <= (tall <= TALL_MIN_C) ? TALL_MIN_C : tall - 10'd1;
          end
        end

        S_JUMP: begin
          if (bus.jump_fin) begin
            land_x  <= bus.man_x;
            jump_en <= 1'b0;
            state   <= S_CHECK;
          end else if (bus.pulse) begin
            if (to_cnt == TO_LAST) begin
              jump_en   <= 1'b0;
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              to_cnt <= to_cnt + 16'd1;
            end
          end
        end

        S_CHECK: begin
          if (in_span(land_x, bus.plat_left, bus.plat_right)) begin
            score       <= (score == 8'hFF) ? score : score + 8'd1;
            moved_man_x <= land_x;
            tall        <= TALL_REST_C;
            state       <= S_SCROLL;
          end else begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end
        end

        S_SCROLL: begin
          // Leave one cycle after the snapping strobe so it is seen inside SCROLL.
          if (scroll_pulse && moved_man_x == HOME_C) begin
            generate_en <= 1'b1;
            state       <= S_NEWPLAT;
          end else if (bus.pulse) begin
            scroll_pulse <= 1'b1;
            moved_man_x  <= (moved_man_x <= SNAP_C) ? HOME_C : moved_man_x - STEP_C;
          end
        end

        S_NEWPLAT: begin
          length <= LEN_MIN_C;
          state  <= S_IDLE;
        end

        S_OVER: begin
          if (key_rise) begin
            score       <= 8'd0;
            moved_man_x <= HOME_C;
            length      <= LEN_MIN_C;
            tall        <= TALL_REST_C;
            game_over   <= 1'b0;
            generate_en <= 1'b1;
            state       <= S_NEWPLAT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.jump_en      = jump_en;
  assign bus.length       = length;
  assign bus.tall         = tall;
  assign bus.moved_man_x  = moved_man_x;
  assign bus.scroll_pulse = scroll_pulse;
  assign bus.generate_en  = generate_en;
  assign bus.score        = score;
  assign bus.game_over    = game_over;

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed game rounds plus randomized
// rounds, with expectations computed from the game rules in plain arithmetic.
module tb_jump_ctrl;

  localparam int HOME  = 60;
  localparam int LMIN  = 20;
  localparam int LMAX  = 600;
  localparam int LSTEP = 4;
  localparam int TREST = 60;
  localparam int TMIN  = 30;
  localparam int SSTEP = 4;
  localparam int TOUT  = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;

  jump_ctrl_if bus();

  jump_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_err     = 0;
  int exp_score = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.pulse = 1'b1;
    step();
    bus.pulse = 1'b0;
    step();
  endtask

  task automatic check_reset_vals(input string ctx);
    check({ctx, "_jump_en"},      32'(bus.jump_en),      0);
    check({ctx, "_length"},       32'(bus.length),       LMIN);
    check({ctx, "_tall"},         32'(bus.tall),         TREST);
    check({ctx, "_moved_man_x"},  32'(bus.moved_man_x),  HOME);
    check({ctx, "_scroll_pulse"}, 32'(bus.scroll_pulse), 0);
    check({ctx, "_generate_en"},  32'(bus.generate_en),  0);
    check({ctx, "_score"},        32'(bus.score),        0);
    check({ctx, "_game_over"},    32'(bus.game_over),    0);
  endtask

  // Fresh key press from OVER: score cleared, one generate_en strobe.
  task automatic restart();
    bus.key = 1'b0;
    step();
    bus.key = 1'b1;
    step();
    exp_score = 0;
    check("restart_gen",       32'(bus.generate_en), 1);
    check("restart_game_over", 32'(bus.game_over),   0);
    check("restart_score",     32'(bus.score),       0);
    check("restart_moved",     32'(bus.moved_man_x), HOME);
    check("restart_length",    32'(bus.length),      LMIN);
    bus.key = 1'b0;
    step();
    check("restart_gen_off",   32'(bus.generate_en), 0);
    check("restart_jump_en",   32'(bus.jump_en),     0);
  endtask

  // Scroll from x back to HOME one pulse at a time, counting observed strobes.
  task automatic scroll_home(input int x);
    int pos     = x;
    int strobes = 0;
    int exp_str = (x <= HOME + SSTEP) ? 1 : (x - HOME + SSTEP - 1) / SSTEP;
    bit done    = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      bus.pulse = 1'b1;
      step();
      bus.pulse = 1'b0;
      strobes += int'(bus.scroll_pulse);
      pos = (pos <= HOME + SSTEP) ? HOME : pos - SSTEP;
      check("scroll_strobe", 32'(bus.scroll_pulse), 1);
      check("scroll_x",      32'(bus.moved_man_x),  pos);
      step();
      check("scroll_strobe_off", 32'(bus.scroll_pulse), 0);
      if (pos == HOME) begin
        check("newplat_gen", 32'(bus.generate_en), 1);
        check("newplat_jump_en", 32'(bus.jump_en), 0);
        step();
        check("newplat_gen_off", 32'(bus.generate_en), 0);
        check("newplat_length",  32'(bus.length),      LMIN);
        done = 1'b1;
      end else begin
        check("scroll_gen_quiet", 32'(bus.generate_en), 0);
      end
    end
    check("scroll_done",    32'(done),    1);
    check("scroll_strobes", 32'(strobes), exp_str);
  endtask

  task automatic charge_and_jump(input int n, input bit coin);
    int len = LMIN;
    int tl  = TREST;
    bus.key = 1'b1;
    step();
    check("charge_len0",  32'(bus.length),  LMIN);
    check("charge_tall0", 32'(bus.tall),    TREST);
    check("charge_jen0",  32'(bus.jump_en), 0);
    for (int i = 0; i < n; i++) begin
      tick();
      len = (len + LSTEP > LMAX) ? LMAX : len + LSTEP;
      tl  = (tl - 1 < TMIN) ? TMIN : tl - 1;
    end
    bus.key   = 1'b0;
    bus.pulse = coin;
    step();
    bus.pulse = 1'b0;
    check("jump_en_on",  32'(bus.jump_en), 1);
    check("jump_length", 32'(bus.length),  len);
    check("jump_tall",   32'(bus.tall),    tl);
  endtask

  task automatic land(input int x, input int pl, input int pr, input bit coin);
    bit hit = (pl <= x) && (x <= pr);
    bus.man_x      = 10'(x);
    bus.plat_left  = 10'(pl);
    bus.plat_right = 10'(pr);
    bus.jump_fin   = 1'b1;
    bus.pulse      = coin;
    step();
    bus.jump_fin = 1'b0;
    bus.pulse    = 1'b0;
    check("land_jump_en",   32'(bus.jump_en),   0);
    check("land_game_over", 32'(bus.game_over), 0);
    step();
    if (hit) begin
      exp_score = (exp_score >= 255) ? 255 : exp_score + 1;
      check("hit_score",     32'(bus.score),       exp_score);
      check("hit_game_over", 32'(bus.game_over),   0);
      check("hit_moved",     32'(bus.moved_man_x), x);
      check("hit_tall",      32'(bus.tall),        TREST);
      scroll_home(x);
    end else begin
      check("miss_game_over", 32'(bus.game_over), 1);
      check("miss_score",     32'(bus.score),     exp_score);
      check("miss_jump_en",   32'(bus.jump_en),   0);
    end
  endtask

  task automatic play(input int n, input bit coin, input int x, input int pl,
                      input int pr, input bit hold);
    bit hit = (pl <= x) && (x <= pr);
    charge_and_jump(n, coin);
    if (hold) bus.key = 1'b1;
    land(x, pl, pr, 1'b0);
    if (!hit) begin
      if (hold) begin
        repeat (3) step();
        check("held_key_no_restart", 32'(bus.game_over),   1);
        check("held_key_no_gen",     32'(bus.generate_en), 0);
      end
      restart();
    end else if (hold) begin
      bus.key = 1'b0;
      step();
    end
  endtask

  initial begin
    bus.pulse      = 1'b0;
    bus.key        = 1'b0;
    bus.jump_fin   = 1'b0;
    bus.man_x      = '0;
    bus.plat_left  = '0;
    bus.plat_right = '0;

    #1 rst = 1'b1;
    #2 check_reset_vals("por");
    step();
    rst = 1'b0;
    step();

    // Charge 10 pulses then hit at 105 on 90..130: 12 scroll strobes.
    play(10, 1'b0, 105, 90, 130, 1'b0);
    // Miss at 140 with key held: no restart until a fresh press.
    play(0, 1'b0, 140, 90, 130, 1'b1);
    // Release coinciding with a pulse adds no step; long hold saturates.
    play(5, 1'b1, 200, 0, 1023, 1'b0);
    play(200, 1'b1, 70, 0, 1023, 1'b0);

    // Timeout after 512 pulses without a landing.
    charge_and_jump(0, 1'b0);
    repeat (TOUT - 1) tick();
    check("timeout_pre_jen",  32'(bus.jump_en),   1);
    check("timeout_pre_over", 32'(bus.game_over), 0);
    tick();
    check("timeout_jen",   32'(bus.jump_en),   0);
    check("timeout_over",  32'(bus.game_over), 1);
    check("timeout_score", 32'(bus.score),     exp_score);
    restart();

    // Landing on the 512th pulse wins over the timeout.
    charge_and_jump(0, 1'b0);
    repeat (TOUT - 1) tick();
    land(100, 0, 1023, 1'b1);

    // Score saturation at 255.
    for (int i = 0; i < 256; i++)
      play(0, 1'b0, int'($urandom_range(40, 72)), 0, 1023, 1'b0);
    check("score_sat", 32'(bus.score), 255);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      int pl = int'($urandom_range(0, 700));
      int pr = pl + int'($urandom_range(0, 300));
      int x  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(pl, pr))
                                           : int'($urandom_range(0, 1023));
      play(int'($urandom_range(0, 160)), 1'($urandom_range(0, 1)), x, pl, pr,
           1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a jump.
    charge_and_jump(3, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_jump");
    #1 rst = 1'b0;
    exp_score = 0;
    step();

    // Asynchronous reset in the middle of a scroll.
    charge_and_jump(0, 1'b0);
    bus.man_x      = 10'd300;
    bus.plat_left  = 10'd0;
    bus.plat_right = 10'd1023;
    bus.jump_fin   = 1'b1;
    step();
    bus.jump_fin = 1'b0;
    step();
    check("pre_rst_score", 32'(bus.score), 1);
    tick();
    check("pre_rst_moved", 32'(bus.moved_man_x), 296);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_scroll");
    #1 rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
